// File: rtl/posit_defines_es3.sv
// Shared definitions for the posit<32,3> datapath: widths, the raw product
// record produced by the ES3 multiplier and its deserializer.
package posit_defines_es3;

  localparam int NBITS = 32;
  localparam int ES    = 3;
  // fraction bits of one operand (no hidden bit) and of the raw product
  localparam int FBITS = NBITS - 3 - ES;
  localparam int MBITS = 2 * FBITS + 1;
  // product scale spans +/-481; eleven signed bits leave headroom
  localparam int SBITS = 11;
  localparam int MAX_SCALE_ES3 = (NBITS - 2) * (1 << ES);
  localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES3 = 3 + SBITS + MBITS;

  typedef struct packed {
    logic                    sgn;
    logic                    zero;
    logic                    inf;
    logic signed [SBITS-1:0] scale;
    logic [MBITS-1:0]        fraction;
  } value_product;

  function automatic value_product deserialize_prod(
    input logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] bits
  );
    value_product v;
    v.sgn      = bits[POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1];
    v.zero     = bits[POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-2];
    v.inf      = bits[POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-3];
    v.scale    = bits[MBITS +: SBITS];
    v.fraction = bits[MBITS-1:0];
    return v;
  endfunction

endpackage

// File: rtl/shift_left.sv
// Logical left shift by a variable amount; zeros enter from the bottom.
module shift_left #(
  parameter int N = 53,
  parameter int S = 6
) (
  input  logic [N-1:0] in,
  input  logic [S-1:0] amt,
  output logic [N-1:0] out
);
  assign out = in << amt;
endmodule

// File: rtl/shift_right.sv
// Logical right shift by a variable amount; zeros enter from the top.
module shift_right #(
  parameter int N = 64,
  parameter int S = 7
) (
  input  logic [N-1:0] in,
  input  logic [S-1:0] amt,
  output logic [N-1:0] out
);
  assign out = in >> amt;
endmodule

// File: rtl/posit_normalize_es3.sv
// Three-stage normalizer: raw ES3 product (sign, flags, scale, fraction) to a
// packed posit<32,3> with round-to-nearest-even and saturation.
module posit_normalize_es3
  import posit_defines_es3::*;
(
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] in,
  input  logic                                          start,
  output logic [NBITS-1:0]                              result,
  output logic                                          inf,
  output logic                                          zero,
  output logic                                          done
);

  localparam int PAD = 2 * NBITS - 5 - MBITS;
  localparam logic signed [SBITS-1:0] SCALE_MAX = SBITS'(MAX_SCALE_ES3);
  localparam logic signed [SBITS-1:0] SCALE_MIN = -SCALE_MAX;
  localparam logic [NBITS-2:0] MAXPOS = {(NBITS-1){1'b1}};
  localparam logic [NBITS-2:0] MINPOS = (NBITS-1)'(1);
  localparam logic [NBITS-1:0] NAR    = {1'b1, {(NBITS-1){1'b0}}};

  // stage 0
  logic         v0_r;
  value_product p0_r;

  // stage 1 combinational
  logic signed [SBITS-1:0] scale_s, k_s, rl_s;
  logic                    neg_s, sat_hi_s, sat_lo_s, bafter_s, sticky_s;
  logic [6:0]              rl_sh_s, drop7_s;
  logic [5:0]              drop_idx_s;
  logic [MBITS-1:0]        mask_hi_s;

  // stage 1 registers
  logic             v1_r, sgn1_r, zero1_r, inf1_r, sat_hi1_r, sat_lo1_r, neg1_r;
  logic             bafter1_r, sticky1_r;
  logic [6:0]       rl1_r;
  logic [ES-1:0]    exp1_r;
  logic [MBITS-1:0] frac1_r;

  // stage 2 combinational
  logic [2*NBITS-1:0] word_s, sh_in_s, sh_out_s, shifted_s;
  logic [NBITS-2:0]   mag_s, mag_rnd_s, mag_fin_s;
  logic               rnd_s;
  logic [NBITS-1:0]   signed_s, res_s;
  logic               unused_s;

  // Stage 0: capture and unpack the operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      v0_r <= 1'b0;
      p0_r <= '0;
    end else begin
      if (start) v0_r <= 1'b1;
      else       v0_r <= 1'b0;
      p0_r <= deserialize_prod(in);
    end
  end

  // Stage 1: regime run length, saturation and the index of the first dropped fraction bit.
  always_comb begin
    scale_s = p0_r.scale;
    k_s     = scale_s >>> 3'd3;
    neg_s   = scale_s[SBITS-1];
    if (neg_s) rl_s = -k_s;
    else       rl_s = k_s + 11'sd1;
    if (rl_s > 11'sd63) rl_sh_s = 7'd63;
    else                rl_sh_s = rl_s[6:0];
    // kept = 27 - rl, so the first dropped bit sits at MBITS-1-kept = 25 + rl
    drop7_s = 7'd25 + rl_sh_s;
    if (rl_sh_s <= 7'd27) drop_idx_s = drop7_s[5:0];
    else                  drop_idx_s = 6'd52;
    sat_hi_s = (scale_s > SCALE_MAX);
    sat_lo_s = (scale_s < SCALE_MIN);
  end

  shift_left #(.N(MBITS), .S(6)) u_sticky_mask (
    .in  ({MBITS{1'b1}}),
    .amt (drop_idx_s),
    .out (mask_hi_s)
  );

  // Stage 1: guard bit and sticky over everything below it.
  always_comb begin
    bafter_s = p0_r.fraction[drop_idx_s];
    sticky_s = |(p0_r.fraction & ~mask_hi_s);
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r <= 1'b0; sgn1_r <= 1'b0; zero1_r <= 1'b0; inf1_r <= 1'b0;
      sat_hi1_r <= 1'b0; sat_lo1_r <= 1'b0; neg1_r <= 1'b0;
      bafter1_r <= 1'b0; sticky1_r <= 1'b0; rl1_r <= '0; exp1_r <= '0; frac1_r <= '0;
    end else begin
      v1_r      <= v0_r;
      sgn1_r    <= p0_r.sgn;
      zero1_r   <= p0_r.zero;
      inf1_r    <= p0_r.inf;
      sat_hi1_r <= sat_hi_s;
      sat_lo1_r <= sat_lo_s;
      neg1_r    <= neg_s;
      bafter1_r <= bafter_s;
      sticky1_r <= sticky_s;
      rl1_r     <= rl_sh_s;
      exp1_r    <= scale_s[ES-1:0];
      frac1_r   <= p0_r.fraction;
    end
  end

  // Stage 2: the inversion turns the logical shift into a fill with the regime bit.
  always_comb begin
    word_s = {~neg1_r, neg1_r, exp1_r, frac1_r, {PAD{1'b0}}};
    if (neg1_r) sh_in_s = word_s;
    else        sh_in_s = ~word_s;
  end

  shift_right #(.N(2*NBITS), .S(7)) u_regime_shift (
    .in  (sh_in_s),
    .amt (rl1_r),
    .out (sh_out_s)
  );

  // Stage 2: round, saturate, apply sign and special values.
  always_comb begin
    if (neg1_r) shifted_s = sh_out_s;
    else        shifted_s = ~sh_out_s;
    mag_s = shifted_s[2*NBITS-2 -: NBITS-1];
    rnd_s = bafter1_r & (sticky1_r | mag_s[0]);
    if (rnd_s && (mag_s != MAXPOS)) mag_rnd_s = mag_s + MINPOS;
    else                            mag_rnd_s = mag_s;
    if (sat_hi1_r)               mag_fin_s = MAXPOS;
    else if (sat_lo1_r)          mag_fin_s = MINPOS;
    else if (mag_rnd_s == '0)    mag_fin_s = MINPOS;
    else                         mag_fin_s = mag_rnd_s;
    if (sgn1_r) signed_s = {1'b1, ~mag_fin_s + MINPOS};
    else        signed_s = {1'b0, mag_fin_s};
    if (inf1_r)       res_s = NAR;
    else if (zero1_r) res_s = '0;
    else              res_s = signed_s;
    unused_s = ^{shifted_s[2*NBITS-1], shifted_s[NBITS-1:0], drop7_s[6]};
  end

  // Stage 3: output register, holds its value between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      inf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= v1_r;
      if (v1_r) begin
        result <= res_s;
        inf    <= inf1_r;
        zero   <= zero1_r & ~inf1_r;
      end
    end
  end

endmodule

// File: tb/tb_posit_normalize_es3.sv
// Scoreboard bench for posit_normalize_es3: directed vectors, a reset-abort
// sequence and a back-to-back burst checked against a bit-string model.
module tb_posit_normalize_es3;
  import posit_defines_es3::*;

  logic clk = 1'b0;
  logic reset, start;
  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] din;
  logic [31:0] result;
  logic inf, zero, done;

  always #5 clk = ~clk;

  posit_normalize_es3 dut (
    .clk(clk), .reset(reset), .in(din), .start(start),
    .result(result), .inf(inf), .zero(zero), .done(done)
  );

  typedef struct {
    logic [31:0] res;
    logic        inf;
    logic        zero;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_m;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic rst_q = 1'b1;
  logic [31:0] last_res = 32'd0;
  logic last_inf = 1'b0, last_zero = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Independent model: lay out regime, exponent and fraction as a bit string.
  function automatic logic [31:0] ref_posit(input logic s, input logic z, input logic i,
                                            input int scale, input logic [52:0] frac);
    logic [127:0] bits;
    logic [30:0]  mag;
    int pos, k, e, rl, kept;
    logic bafter, sticky;
    if (i) return 32'h80000000;
    if (z) return 32'h00000000;
    if (scale > 240) mag = 31'h7FFFFFFF;
    else if (scale < -240) mag = 31'd1;
    else begin
      k = (scale >= 0) ? scale / 8 : -((7 - scale) / 8);
      e = scale - 8 * k;
      bits = '0;
      pos = 127;
      if (k >= 0) begin
        for (int n = 0; n <= k; n++) begin bits[pos] = 1'b1; pos--; end
        pos--;
      end else begin
        pos = pos + k;
        bits[pos] = 1'b1;
        pos--;
      end
      for (int n = 2; n >= 0; n--) begin bits[pos] = ((e >> n) & 1) != 0; pos--; end
      for (int n = 52; n >= 0; n--) begin bits[pos] = frac[n]; pos--; end
      mag = bits[127:97];
      rl = (k >= 0) ? k + 1 : -k;
      kept = 27 - rl;
      if (kept < 0) kept = 0;
      bafter = frac[52 - kept];
      sticky = 1'b0;
      for (int n = 0; n < 52 - kept; n++) sticky = sticky | frac[n];
      if (bafter && (sticky || mag[0]) && mag != 31'h7FFFFFFF) mag = mag + 31'd1;
      if (mag == 31'd0) mag = 31'd1;
    end
    if (s) return {1'b1, ~mag + 31'd1};
    return {1'b0, mag};
  endfunction

  task automatic drive(input logic s, input logic z, input logic i, input int scale,
                       input logic [52:0] frac);
    value_product p;
    p.sgn = s; p.zero = z; p.inf = i;
    p.scale = scale[SBITS-1:0];
    p.fraction = frac;
    din = p;
    start = 1'b1;
  endtask

  // Drive immediately and record the required response.
  task automatic send_now(input logic s, input logic z, input logic i, input int scale,
                          input logic [52:0] frac, input logic [31:0] r, input logic ri,
                          input logic rz, input string name);
    exp_t e;
    drive(s, z, i, scale, frac);
    e.res = r; e.inf = ri; e.zero = rz; e.cyc = cyc; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic s, input logic z, input logic i, input int scale,
                      input logic [52:0] frac, input logic [31:0] r, input logic ri,
                      input logic rz, input string name);
    @(posedge clk); #1;
    send_now(s, z, i, scale, frac, r, ri, rz, name);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d results outstanding, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: compare every presented result, check reset values and holding.
  always @(negedge clk) begin
    if (rst_q) begin
      n_cmp++;
      if (done !== 1'b0 || result !== 32'd0 || inf !== 1'b0 || zero !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: done=%b result=%h inf=%b zero=%b, required all 0",
                 done, result, inf, zero);
      end
      last_res = 32'd0; last_inf = 1'b0; last_zero = 1'b0;
    end else if (done) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, required no done", result, cyc);
      end else begin
        e_m = sb_q.pop_front();
        if (result !== e_m.res || inf !== e_m.inf || zero !== e_m.zero) begin
          n_fail++;
          $display("FAIL %s: result=%h inf=%b zero=%b, required result=%h inf=%b zero=%b",
                   e_m.name, result, inf, zero, e_m.res, e_m.inf, e_m.zero);
        end
        n_cmp++;
        if (cyc - e_m.cyc != 3) begin
          n_fail++;
          $display("FAIL %s_latency: done after %0d cycles, required 3", e_m.name, cyc - e_m.cyc);
        end
        last_res = e_m.res; last_inf = e_m.inf; last_zero = e_m.zero;
      end
    end else begin
      n_cmp++;
      if (result !== last_res || inf !== last_inf || zero !== last_zero) begin
        n_fail++;
        $display("FAIL hold: result=%h inf=%b zero=%b, required result=%h inf=%b zero=%b",
                 result, inf, zero, last_res, last_inf, last_zero);
      end
    end
  end

  initial begin
    int sc;
    logic s;
    logic [63:0] r64;
    reset = 1'b1; start = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    send(1'b0, 1'b0, 1'b0, 0, 53'd0, 32'h40000000, 1'b0, 1'b0, "one");
    idle();
    drain("single");

    send(1'b0, 1'b0, 1'b0,    1, 53'd0, 32'h44000000, 1'b0, 1'b0, "scale_p1");
    send(1'b0, 1'b0, 1'b0,   -1, 53'd0, 32'h3C000000, 1'b0, 1'b0, "scale_m1");
    send(1'b1, 1'b0, 1'b0,    0, 53'd0, 32'hC0000000, 1'b0, 1'b0, "minus_one");
    send(1'b0, 1'b0, 1'b0,    8, 53'd0, 32'h60000000, 1'b0, 1'b0, "scale_p8");
    send(1'b0, 1'b0, 1'b0,   -8, 53'd0, 32'h20000000, 1'b0, 1'b0, "scale_m8");
    send(1'b0, 1'b0, 1'b0,  300, 53'd0, 32'h7FFFFFFF, 1'b0, 1'b0, "sat_max");
    send(1'b0, 1'b0, 1'b0, -300, 53'd0, 32'h00000001, 1'b0, 1'b0, "sat_min");
    send(1'b1, 1'b0, 1'b0, -300, 53'd0, 32'hFFFFFFFF, 1'b0, 1'b0, "sat_min_neg");
    send(1'b0, 1'b0, 1'b0,  240, 53'd0, 32'h7FFFFFFF, 1'b0, 1'b0, "scale_240");
    send(1'b0, 1'b0, 1'b0, -240, 53'd0, 32'h00000001, 1'b0, 1'b0, "scale_m240");
    send(1'b0, 1'b1, 1'b0,    5, 53'd7, 32'h00000000, 1'b0, 1'b1, "zero_in");
    send(1'b1, 1'b1, 1'b1,    5, 53'd7, 32'h80000000, 1'b1, 1'b0, "nar_in");
    send(1'b0, 1'b0, 1'b0,    0, 53'h4000000, 32'h40000000, 1'b0, 1'b0, "rne_tie_even");
    send(1'b0, 1'b0, 1'b0,    0, 53'hC000000, 32'h40000002, 1'b0, 1'b0, "rne_tie_odd");
    send(1'b0, 1'b0, 1'b0,    0, 53'h4000001, 32'h40000001, 1'b0, 1'b0, "rne_above");
    idle();
    drain("directed");

    // two starts, then reset: neither may complete
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 1, 53'd0);
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b0, 2, 53'd0);
    @(posedge clk); #1 start = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    send_now(1'b0, 1'b0, 1'b0, 1, 53'd0, 32'h44000000, 1'b0, 1'b0, "after_reset");
    idle();
    drain("reset");

    for (int n = 0; n < 10; n++) begin
      sc = int'($urandom_range(520, 0)) - 260;
      s = 1'($urandom_range(1, 0));
      r64 = {$urandom(), $urandom()};
      send(s, 1'b0, 1'b0, sc, r64[52:0], ref_posit(s, 1'b0, 1'b0, sc, r64[52:0]),
           1'b0, 1'b0, $sformatf("burst%0d", n));
    end
    idle();
    drain("burst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
